// File: rtl/counter_modulo_n_cascade_pkg.sv
// Shared definitions for the cascaded modulo-N counter.
//   COUNT_UP / COUNT_DOWN : encodings of the up_down input
//   n_fits()              : elaboration-time check that a modulus fits a digit
package counter_modulo_n_cascade_pkg;

  localparam logic COUNT_UP   = 1'b1;
  localparam logic COUNT_DOWN = 1'b0;

  // True when values 0..n-1 are representable in w bits.
  function automatic bit n_fits(input int n, input int w);
    return (n >= 2) && ($clog2(n) <= w);
  endfunction

endpackage

// File: rtl/counter_modulo_n_digit.sv
// One modulo-N digit of the cascade.
//   clk, reset  : clock, synchronous active-high reset
//   adv_in      : step this digit on the edge (all lower digits at terminal)
//   up_down     : 1 = up, 0 = down
//   load        : parallel load of load_digit (saturated to N-1); beats adv_in
//   load_digit  : preset value for this digit
//   digit_out   : registered digit value
//   at_term     : digit sits at N-1 (up) or 0 (down)
module counter_modulo_n_digit
  import counter_modulo_n_cascade_pkg::*;
#(
  parameter int N         = 10,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 adv_in,
  input  logic                 up_down,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_digit,
  output logic [CNT_WIDTH-1:0] digit_out,
  output logic                 at_term
);

  localparam logic [CNT_WIDTH-1:0] MAX = CNT_WIDTH'(N - 1);
  // One extra bit so N == 2**CNT_WIDTH still compares correctly.
  localparam logic [CNT_WIDTH:0]   N_X = (CNT_WIDTH + 1)'(N);

  logic [CNT_WIDTH-1:0] q;

  assign digit_out = q;
  assign at_term   = (up_down == COUNT_UP) ? (q == MAX) : (q == '0);

  always_ff @(posedge clk) begin
    if (reset)
      q <= '0;
    else if (load)
      q <= ({1'b0, load_digit} >= N_X) ? MAX : load_digit;
    else if (adv_in) begin
      if (up_down == COUNT_UP)
        q <= (q == MAX) ? '0 : q + 1'b1;
      else
        q <= (q == '0) ? MAX : q - 1'b1;
    end
  end

endmodule

// File: rtl/counter_modulo_n_cascade.sv
// Cascadable modulo-N up/down counter with parallel load and wrap pulse.
//   clk, reset : clock, synchronous active-high reset
//   enable     : advance by one on the edge
//   up_down    : 1 = up, 0 = down (evaluated on every enabled edge)
//   load       : parallel load of load_value (per-digit saturate to N-1)
//   load_value : preset, digit k at [k*CNT_WIDTH +: CNT_WIDTH]
//   count_out  : current count, same packing
//   terminal   : combinational, every digit at its terminal value
//   wrap       : registered one-cycle pulse after a full rollover
module counter_modulo_n_cascade
  import counter_modulo_n_cascade_pkg::*;
#(
  parameter int N         = 10,
  parameter int CNT_WIDTH = 4,
  parameter int DIGITS    = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          up_down,
  input  logic                          load,
  input  logic [DIGITS*CNT_WIDTH-1:0]   load_value,
  output logic [DIGITS*CNT_WIDTH-1:0]   count_out,
  output logic                          terminal,
  output logic                          wrap
);

  if (!n_fits(N, CNT_WIDTH)) begin : g_bad_n
    $error("counter_modulo_n_cascade: N must satisfy 2 <= N <= 2**CNT_WIDTH");
  end
  if (DIGITS < 1) begin : g_bad_digits
    $error("counter_modulo_n_cascade: DIGITS must be >= 1");
  end

  logic [DIGITS-1:0] at_term;
  // adv[k] : digit k steps this edge; ripple AND of lower at_term flags.
  logic [DIGITS:0]   adv;

  assign adv[0] = enable;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    assign adv[k+1] = adv[k] & at_term[k];

    counter_modulo_n_digit #(
      .N         (N),
      .CNT_WIDTH (CNT_WIDTH)
    ) u_digit (
      .clk        (clk),
      .reset      (reset),
      .adv_in     (adv[k]),
      .up_down    (up_down),
      .load       (load),
      .load_digit (load_value[k*CNT_WIDTH +: CNT_WIDTH]),
      .digit_out  (count_out[k*CNT_WIDTH +: CNT_WIDTH]),
      .at_term    (at_term[k])
    );
  end

  // No enable term here: terminal depends only on the digits and direction.
  assign terminal = &at_term;

  always_ff @(posedge clk) begin
    if (reset || load)
      wrap <= 1'b0;
    else
      wrap <= enable & terminal;
  end

endmodule

// File: tb/tb_counter_modulo_n_cascade.sv
module tb_counter_modulo_n_cascade;

  localparam int N         = 10;
  localparam int CNT_WIDTH = 4;
  localparam int DIGITS    = 3;
  localparam int W         = DIGITS * CNT_WIDTH;
  localparam int MOD       = N ** DIGITS;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic         up_down = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] load_value = '0;
  logic [W-1:0] count_out;
  logic         terminal;
  logic         wrap;

  counter_modulo_n_cascade #(
    .N         (N),
    .CNT_WIDTH (CNT_WIDTH),
    .DIGITS    (DIGITS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .up_down    (up_down),
    .load       (load),
    .load_value (load_value),
    .count_out  (count_out),
    .terminal   (terminal),
    .wrap       (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] cnt;
    logic         wrp;
    logic         term;
    int           val;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: the count as a plain integer in 0..MOD-1.
  int mval = 0;
  bit mwrap = 1'b0;

  function automatic logic [W-1:0] to_digits(input int v);
    logic [W-1:0] r;
    int p;
    r = '0;
    p = v;
    for (int k = 0; k < DIGITS; k++) begin
      r[k*CNT_WIDTH +: CNT_WIDTH] = CNT_WIDTH'(p % N);
      p = p / N;
    end
    return r;
  endfunction

  function automatic int dec(input int v);
    return v;
  endfunction

  task automatic step(input bit r, input bit e, input bit ud, input bit l,
                      input logic [W-1:0] lv);
    exp_t x;
    int d;
    @(negedge clk);
    reset = r; enable = e; up_down = ud; load = l; load_value = lv;
    if (r) begin
      mval = 0; mwrap = 1'b0;
    end else if (l) begin
      mval = 0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
        d = int'(lv[k*CNT_WIDTH +: CNT_WIDTH]);
        if (d > N - 1) d = N - 1;
        mval = mval * N + d;
      end
      mwrap = 1'b0;
    end else if (e) begin
      if (ud) begin
        mwrap = (mval == MOD - 1);
        mval  = (mval + 1) % MOD;
      end else begin
        mwrap = (mval == 0);
        mval  = (mval + MOD - 1) % MOD;
      end
    end else begin
      mwrap = 1'b0;
    end
    x.cnt  = to_digits(mval);
    x.wrp  = mwrap;
    x.term = ud ? (mval == MOD - 1) : (mval == 0);
    x.val  = dec(mval);
    q.push_back(x);
  endtask

  // Monitor: each sampled edge has one expected entry queued by the driver.
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (q.size() > 0) begin
      x = q.pop_front();
      checks++;
      if (count_out !== x.cnt) begin
        errors++;
        $display("FAIL count_out got %h exp %h (value %0d)", count_out, x.cnt, x.val);
      end
      checks++;
      if (wrap !== x.wrp) begin
        errors++;
        $display("FAIL wrap got %b exp %b at value %0d", wrap, x.wrp, x.val);
      end
      checks++;
      if (terminal !== x.term) begin
        errors++;
        $display("FAIL terminal got %b exp %b at value %0d", terminal, x.term, x.val);
      end
    end
  end

  initial begin
    logic [W-1:0] picks [6];
    logic [W-1:0] lv;
    bit dir;
    picks[0] = 12'h998; picks[1] = 12'h999; picks[2] = 12'h000;
    picks[3] = 12'h001; picks[4] = 12'h909; picks[5] = 12'h090;

    // reset, then 12 up counts -> 012, no wrap
    step(1, 0, 1, 0, '0);
    for (int i = 0; i < 12; i++) step(0, 1, 1, 0, '0);

    // 998 -> 999 -> 000 with wrap after rollover
    step(0, 0, 1, 1, 12'h998);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, '0);
    step(0, 0, 1, 0, '0);

    // down: 001 -> 000 -> 999
    step(0, 0, 0, 1, 12'h001);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, '0);

    // at 999 up: load+enable with saturating digit -> 095, no wrap
    step(0, 0, 1, 1, 12'h999);
    step(0, 1, 1, 1, 12'h0F5);
    step(0, 0, 1, 0, '0);

    // enable toggling to 055, then direction flip -> 054
    step(0, 0, 1, 1, 12'h053);
    step(0, 1, 1, 0, '0);
    step(0, 0, 1, 0, '0);
    step(0, 1, 1, 0, '0);
    step(0, 1, 0, 0, '0);

    // reset beats load+enable at 437, then resume
    step(0, 0, 1, 1, 12'h437);
    step(1, 1, 1, 1, 12'h437);
    step(0, 1, 1, 0, '0);
    step(0, 1, 1, 0, '0);

    // randomized traffic
    dir = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) dir = ~dir;
      if ($urandom_range(0, 1) == 0) lv = picks[$urandom_range(0, 5)];
      else lv = W'($urandom);
      step($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, dir,
           $urandom_range(0, 24) == 0, lv);
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
